// File: rtl/hitlc_pkg.sv
// Shared constants and types for the hit/long-cluster layer sequencer.
// Default layer count and pipeline depth, the FSM state enum and the beat tag layout.
package hitlc_pkg;

    localparam int HITLC_NLAYER   = 6;
    localparam int SEL_W          = 3;
    localparam int HITLC_PIPE_LAT = 2;
    localparam int CNT_W          = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] layer;
        logic             last;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, layer: {SEL_W{1'b0}}, last: 1'b0};

endpackage

// File: rtl/hitlc_next_layer.sv
// Combinational finder: the next set mask bit strictly above cur_idx.
// When none exists, last is raised and next_idx echoes cur_idx.
module hitlc_next_layer
    import hitlc_pkg::*;
#(
    parameter int NLAYER = HITLC_NLAYER
) (
    input  logic [NLAYER-1:0] mask,
    input  logic [SEL_W-1:0]  cur_idx,
    output logic [SEL_W-1:0]  next_idx,
    output logic              last
);

    // Walk downward so the lowest qualifying bit is the one left standing.
    always_comb begin
        next_idx = cur_idx;
        last     = 1'b1;
        for (int i = NLAYER - 1; i >= 0; i--) begin
            next_idx = (mask[i] && (i > int'(cur_idx))) ? SEL_W'(i) : next_idx;
            last     = (mask[i] && (i > int'(cur_idx))) ? 1'b0 : last;
        end
    end

endmodule

// File: rtl/hitlc_seq.sv
// Walks each accepted track's layer mask through sel_chi, one layer per clock, and emits
// beat tags aligned to the mux's registered outputs. Define HITLC_SEQ_HITCOUNT_EN for nhit.
module hitlc_seq
    import hitlc_pkg::*;
#(
    parameter int NLAYER   = HITLC_NLAYER,
    parameter int PIPE_LAT = HITLC_PIPE_LAT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              track_valid,
    input  logic [NLAYER-1:0] track_mask,
    output logic              track_ready,
    output logic [SEL_W-1:0]  sel_chi,
    output logic              scan_active,
    input  logic [4:0]        hitmap_current,
    output logic              out_valid,
    output logic [SEL_W-1:0]  out_layer,
    output logic              out_last,
    output logic              done,
    output logic [CNT_W-1:0]  nhit
);

    localparam logic [NLAYER-1:0] BIT0 = {{(NLAYER-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [NLAYER-1:0] mask_q, mask_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    tag_t              pipe_q [PIPE_LAT];
    tag_t              pipe_d [PIPE_LAT];
    tag_t              issue_s;
    logic [SEL_W-1:0]  next_idx_s;
    logic [SEL_W-1:0]  low_idx_s;
    logic              next_last_s;
    logic              issue_last_s;
    logic              ready_s;
    logic              accept_s;
    logic              load_s;

    hitlc_next_layer #(.NLAYER(NLAYER)) u_next (
        .mask     (mask_q),
        .cur_idx  (sel_q),
        .next_idx (next_idx_s),
        .last     (next_last_s)
    );

    // Ready on the final issue of a track lets the next track start without a bubble.
    assign issue_last_s = (state_q == SCAN) && next_last_s;
    assign ready_s      = (state_q == IDLE) || issue_last_s;
    assign accept_s     = track_valid && ready_s;
    assign load_s       = accept_s && (track_mask != {NLAYER{1'b0}});

    // Lowest set bit of the incoming mask becomes the first select.
    always_comb begin
        low_idx_s = {SEL_W{1'b0}};
        for (int i = NLAYER - 1; i >= 0; i--) begin
            low_idx_s = track_mask[i] ? SEL_W'(i) : low_idx_s;
        end
    end

    // Next-state logic: each SCAN cycle issues sel_q, then advances or reloads.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        issue_s = TAG_IDLE;
        case (state_q)
            IDLE: begin
                if (load_s) begin
                    state_d = SCAN;
                    mask_d  = track_mask;
                    sel_d   = low_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                issue_s = '{valid: 1'b1, layer: sel_q, last: next_last_s};
                if (!next_last_s) begin
                    mask_d = mask_q & ~(BIT0 << sel_q);
                    sel_d  = next_idx_s;
                end else if (load_s) begin
                    mask_d = track_mask;
                    sel_d  = low_idx_s;
                end else begin
                    mask_d  = mask_q & ~(BIT0 << sel_q);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tag delay line matching the mux output latency.
    always_comb begin
        pipe_d[0] = issue_s;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Sequencer state, select register and tag pipeline.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mask_q  <= {NLAYER{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= TAG_IDLE;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign track_ready = ready_s;
    assign sel_chi     = sel_q;
    assign scan_active = (state_q == SCAN);
    assign out_valid   = pipe_q[PIPE_LAT-1].valid;
    assign out_layer   = pipe_q[PIPE_LAT-1].layer;
    assign out_last    = pipe_q[PIPE_LAT-1].last;
    assign done        = pipe_q[PIPE_LAT-1].valid && pipe_q[PIPE_LAT-1].last;

`ifdef HITLC_SEQ_HITCOUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, final_cnt_s;
    logic [CNT_W-1:0] nhit_pipe_q [PIPE_LAT];
    logic [CNT_W-1:0] nhit_pipe_d [PIPE_LAT];

    assign final_cnt_s = cnt_q + {{(CNT_W-1){1'b0}}, (hitmap_current != 5'd0)};

    // Stage 0 only moves on a final issue, so the output stage holds between done pulses.
    always_comb begin
        cnt_d          = accept_s ? {CNT_W{1'b0}} : (issue_s.valid ? final_cnt_s : cnt_q);
        nhit_pipe_d[0] = issue_last_s ? final_cnt_s : nhit_pipe_q[0];
        for (int i = 1; i < PIPE_LAT; i++) begin
            nhit_pipe_d[i] = nhit_pipe_q[i-1];
        end
    end

    // Hit counter and its delay line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < PIPE_LAT; i++) begin
                nhit_pipe_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                nhit_pipe_q[i] <= nhit_pipe_d[i];
            end
        end
    end

    assign nhit = nhit_pipe_q[PIPE_LAT-1];
`else
    logic unused_hitmap_s;
    assign unused_hitmap_s = ^hitmap_current;
    assign nhit            = {CNT_W{1'b0}};
`endif

endmodule
